// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with thresholds, sticky errors, optional FWFT (FIFO_FWFT_EN)
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic                       pop_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CW     = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [CW-1:0]         count_next;

    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // A pop on a full FIFO frees a slot, so a simultaneous push is accepted.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Next occupancy, used so that flags register in step with count.
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers, occupancy, status flags and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_next;
            full         <= (count_next == CW'(DEPTH));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CW'(AF_LEVEL));
            almost_empty <= (count_next <= CW'(AE_LEVEL));
            // A new error event takes priority over a clear in the same cycle.
            overflow     <= (push & ~push_ok) | (overflow & ~clr_err);
            underflow    <= (pop & empty) | (underflow & ~clr_err);
        end
    end

    // Storage write; contents survive reset, but no write happens during it.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_addr] <= push_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; pop only acknowledges it.
    assign pop_data  = empty ? '0 : mem[rd_addr];
    assign pop_valid = ~empty;
`else
    // Registered read: the popped word appears one edge after the pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            if (pop_ok) begin
                pop_data <= mem[rd_addr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head-word check before the pop edge (fall-through mode only).
    task automatic pre_pop(input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
        chk("fwft_data", pop_data, exp);
        chk("fwft_valid", pop_valid, 1);
`else
        exp = exp;
`endif
    endtask

    // Popped-word check after the pop edge (registered mode only).
    task automatic post_pop(input logic [7:0] exp);
`ifndef FIFO_FWFT_EN
        chk("pop_data", pop_data, exp);
        chk("pop_valid", pop_valid, 1);
`else
        exp = exp;
`endif
    endtask

    initial begin
        logic [7:0] mq[$];
        logic [7:0] exp_w;
        int sent;
        int got;
        int cyc;

        rst = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; clr_err = 1'b0;
        step(); step();
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_valid", pop_valid, 0);
        chk("rst_data", pop_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst = 1'b1;
        step();
        chk("idle_empty", empty, 1);
        chk("idle_count", count, 0);

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; push_data = 8'(i);
            step();
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
            chk("fill_full", full, (i + 1 == 16) ? 1 : 0);
            chk("fill_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end
        push_data = 8'hAA;
        step();
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);

        // Drain in order
        push = 1'b0; pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pre_pop(8'(i));
            step();
            post_pop(8'(i));
            chk("drain_count", count, 15 - i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_ae", almost_empty, 1);
        step();
        chk("unf_flag", underflow, 1);
        chk("unf_valid", pop_valid, 0);
        chk("unf_count", count, 0);
        pop = 1'b0; clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);

        // Push+pop on full
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_data = 8'(8'h10 + i);
            step();
        end
        chk("refill_full", full, 1);
        push_data = 8'h55; pop = 1'b1;
        pre_pop(8'h10);
        step();
        post_pop(8'h10);
        chk("pp_full_count", count, 16);
        chk("pp_full_ovf", overflow, 0);
        push = 1'b0;
        for (int i = 1; i < 16; i++) begin
            pre_pop(8'(8'h10 + i));
            step();
            post_pop(8'(8'h10 + i));
        end
        pre_pop(8'h55);
        step();
        post_pop(8'h55);
        chk("pp_last_empty", empty, 1);

        // Push+pop on empty: only the push lands
        push = 1'b1; push_data = 8'h77; pop = 1'b1;
        step();
        chk("ppe_count", count, 1);
        chk("ppe_unf", underflow, 1);
        chk("ppe_empty", empty, 0);
`ifndef FIFO_FWFT_EN
        chk("ppe_valid", pop_valid, 0);
`endif
        push = 1'b0; pop = 1'b0; clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ppe_clr", underflow, 0);
        pop = 1'b1;
        pre_pop(8'h77);
        step();
        post_pop(8'h77);
        pop = 1'b0;
        chk("ppe_drain_empty", empty, 1);

        // Random-gap traffic across pointer wrap
        sent = 0; got = 0; cyc = 0;
        while (got < 40 && cyc < 2000) begin
            bit pu;
            bit po;
            po = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
            pu = (sent < 40) && ($urandom_range(0, 3) != 0) && (mq.size() < 16 || po);
            push = pu; pop = po; push_data = 8'(8'hC0 + sent);
            if (po) begin
                exp_w = mq.pop_front();
                pre_pop(exp_w);
            end
            if (pu) begin
                mq.push_back(push_data);
                sent++;
            end
            step();
            if (po) begin
                post_pop(exp_w);
                got++;
            end
            chk("rnd_count", count, mq.size());
            cyc++;
        end
        push = 1'b0; pop = 1'b0;
        chk("rnd_done", got, 40);
        chk("rnd_errs", overflow | underflow, 0);

        // Mid-operation reset
        push = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_data = 8'(i + 1);
            step();
        end
        push = 1'b0;
        chk("pre_rst_count", count, 9);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_valid", pop_valid, 0);
        chk("mid_rst_full", full, 0);

        // Single word through an empty FIFO
        push = 1'b1; push_data = 8'h3C;
        step();
        push = 1'b0;
`ifdef FIFO_FWFT_EN
        chk("fwft_3c_data", pop_data, 8'h3C);
        chk("fwft_3c_valid", pop_valid, 1);
`else
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("std_3c_data", pop_data, 8'h3C);
        chk("std_3c_valid", pop_valid, 1);
        step();
        chk("std_3c_valid_drop", pop_valid, 0);
        chk("std_3c_hold", pop_data, 8'h3C);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
